// File: rtl/cpu_types_pkg.sv
// Shared core types. The hazard unit uses the state enum and the zero-register index.
package cpu_types_pkg;

  typedef enum logic [1:0] {RUN, DWAIT, HALT} hzstate_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; it holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline-register sequencing for the 5-stage core: stage enables, flushes and PC enable,
// arbitrating memory latency, load-use hazards, redirects and halt.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_halt,
  input  logic             ex_memtoreg,
  input  logic             ex_wen,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_jump,
  input  logic             ex_pcsrc,
  output logic             ifW,
  output logic             idW,
  output logic             exW,
  output logic             memW,
  output logic             ifRST,
  output logic             idRST,
  output logic             exRST,
  output logic             memRST,
  output logic             pc_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzstate_t state_q, state_d;
  logic     mem_busy, load_use, fok, halted;
  logic     ex_pcsrc_hold;

  assign ex_pcsrc_hold = 1'b0;
  assign halted        = (state_q == HALT);
  assign mem_busy      = (mem_dren | mem_dwen) & ~dhit;
  assign load_use      = ex_memtoreg & ex_wen & (ex_wsel != REG_ZERO) &
                         ((ex_wsel == id_rs) | (ex_wsel == id_rt));

  always_comb begin
    ifW = 1'b0; idW = 1'b0; exW = 1'b0; memW = 1'b0;
    ifRST = 1'b0; idRST = 1'b0; exRST = 1'b0; memRST = 1'b0;
    pc_en = 1'b0;
    fok   = 1'b0;
    if (!nRST) begin
      ifRST = 1'b1; idRST = 1'b1; exRST = 1'b1; memRST = 1'b1;
    end else if (!halted) begin
      memW  = ~mem_busy;
      exW   = ~mem_busy;
      fok   = memW & ihit;
      idW   = fok;
      ifW   = fok & ~load_use & ~ex_pcsrc_hold;
      pc_en = ifW;
      exRST = exW & ~idW;
      // Redirects are only acted on when the frontend advances; otherwise the held
      // ID/EX registers keep presenting them until the next fetch completes.
      if (fok) begin
        if (ex_pcsrc) begin
          ifRST = 1'b1; idRST = 1'b1; ifW = 1'b1; pc_en = 1'b1;
        end else if (load_use) begin
          idRST = 1'b1;
        end else if (id_jump) begin
          ifRST = 1'b1; pc_en = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (memW && mem_halt) state_d = HALT;
        else if (mem_busy)    state_d = DWAIT;
      end
      DWAIT: begin
        if (memW && mem_halt) state_d = HALT;
        else if (dhit)        state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign halt = halted;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (~halted & ~pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (ifRST),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: vector table, directed corner sequences and random stimulus
// against a behavioural model of the stage-control rules.
module tb_hazard_control_unit;

  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       ihit, dhit, dren, dwen, mhalt, m2r, wen;
    logic [4:0] wsel, rs, rt;
    logic       jump, pcsrc;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [8:0] exp;
  } vec_t;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             ihit, dhit, mem_dren, mem_dwen, mem_halt, ex_memtoreg, ex_wen;
  logic [4:0]       ex_wsel, id_rs, id_rt;
  logic             id_jump, ex_pcsrc;
  logic             ifW, idW, exW, memW, ifRST, idRST, exRST, memRST, pc_en, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0]       outs;

  int nchk = 0;
  int nbad = 0;

  bit m_halted;
  int m_stall, m_flush;

  always #5 CLK = ~CLK;

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren),
    .mem_dwen(mem_dwen), .mem_halt(mem_halt), .ex_memtoreg(ex_memtoreg), .ex_wen(ex_wen),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_jump(id_jump), .ex_pcsrc(ex_pcsrc),
    .ifW(ifW), .idW(idW), .exW(exW), .memW(memW), .ifRST(ifRST), .idRST(idRST),
    .exRST(exRST), .memRST(memRST), .pc_en(pc_en), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {ifW,idW,exW,memW,ifRST,idRST,exRST,memRST,pc_en}
  assign outs = {ifW, idW, exW, memW, ifRST, idRST, exRST, memRST, pc_en};

  function automatic stim_t mk(input logic ih, dh, dr, dw, mh, m2r, wen,
                               input logic [4:0] ws, rs, rt, input logic jmp, pcs);
    stim_t s;
    s = '{ihit:ih, dhit:dh, dren:dr, dwen:dw, mhalt:mh, m2r:m2r, wen:wen,
          wsel:ws, rs:rs, rt:rt, jump:jmp, pcsrc:pcs};
    return s;
  endfunction

  // Expected outputs, written case by case from the stage-control rules.
  function automatic logic [8:0] ref_outs(input bit in_reset, input bit halted, input stim_t s);
    bit busy, lu, back, fetch;
    if (in_reset) return 9'b0000_1111_0;
    if (halted)   return 9'b0;
    busy  = (s.dren || s.dwen) && !s.dhit;
    lu    = s.m2r && s.wen && (s.wsel != 0) && (s.wsel == s.rs || s.wsel == s.rt);
    back  = !busy;
    fetch = back && s.ihit;
    if (!back)  return 9'b0;
    if (!fetch) return 9'b0011_0010_0;
    if (s.pcsrc) return 9'b1111_1100_1;
    if (lu)      return 9'b0111_0100_0;
    if (s.jump)  return 9'b1111_1000_1;
    return 9'b1111_0000_1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    ihit = s.ihit; dhit = s.dhit; mem_dren = s.dren; mem_dwen = s.dwen;
    mem_halt = s.mhalt; ex_memtoreg = s.m2r; ex_wen = s.wen; ex_wsel = s.wsel;
    id_rs = s.rs; id_rt = s.rt; id_jump = s.jump; ex_pcsrc = s.pcsrc;
  endtask

  task automatic model_advance(input stim_t s);
    logic [8:0] e;
    e = ref_outs(1'b0, m_halted, s);
    if (!m_halted) begin
      if (!e[0] && m_stall < CMAX) m_stall++;
      if (e[4] && m_flush < CMAX)  m_flush++;
      if (e[5] && s.mhalt) m_halted = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string name, input stim_t s);
    drive(s);
    #2;
    check({name, "_outs"}, 32'(outs), 32'(ref_outs(1'b0, m_halted, s)));
    check({name, "_halt"}, 32'(halt), 32'(m_halted));
    check({name, "_stall"}, 32'(stall_cnt), 32'(m_stall));
    check({name, "_flush"}, 32'(flush_cnt), 32'(m_flush));
    model_advance(s);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive('0);
    #2;
    check("rst_outs", 32'(outs), 32'h01E);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_cnts", {16'(stall_cnt), 16'(flush_cnt)}, 32'h0);
    m_halted = 1'b0; m_stall = 0; m_flush = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  vec_t tbl[13];

  initial begin
    drive('0);
    tbl[0]  = '{mk(1,0,0,0,0,0,0,0,0,0,0,0), 9'b1111_0000_1};
    tbl[1]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,0), 9'b0011_0010_0};
    tbl[2]  = '{mk(1,0,1,0,0,0,0,0,0,0,0,0), 9'b0000_0000_0};
    tbl[3]  = '{mk(1,1,0,1,0,0,0,0,0,0,0,0), 9'b1111_0000_1};
    tbl[4]  = '{mk(1,0,0,0,0,1,1,5,5,3,0,0), 9'b0111_0100_0};
    tbl[5]  = '{mk(1,0,0,0,0,1,1,7,2,7,0,0), 9'b0111_0100_0};
    tbl[6]  = '{mk(1,0,0,0,0,1,1,0,0,0,0,0), 9'b1111_0000_1};
    tbl[7]  = '{mk(1,0,0,0,0,1,0,5,5,5,0,0), 9'b1111_0000_1};
    tbl[8]  = '{mk(1,0,0,0,0,1,1,5,5,5,0,1), 9'b1111_1100_1};
    tbl[9]  = '{mk(1,0,0,0,0,0,0,0,0,0,1,0), 9'b1111_1000_1};
    tbl[10] = '{mk(1,0,0,0,0,1,1,9,1,9,1,0), 9'b0111_0100_0};
    tbl[11] = '{mk(0,0,0,0,0,0,0,0,0,0,0,1), 9'b0011_0010_0};
    tbl[12] = '{mk(1,0,1,0,0,0,0,0,0,0,1,0), 9'b0000_0000_0};

    @(negedge CLK);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].s);
      #2;
      check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
      model_advance(tbl[i].s);
      @(negedge CLK);
    end

    // Free-running fetch: every stage advances, no stalls.
    do_reset();
    for (int i = 0; i < 10; i++) step("run", mk(1,0,0,0,0,0,0,0,0,0,0,0));
    check("run_stall0", 32'(stall_cnt), 32'd0);

    // Load-use: exactly one bubble.
    do_reset();
    step("lu", mk(1,0,0,0,0,1,1,5,5,0,0,0));
    step("lu_next", mk(1,0,0,0,0,0,0,0,5,0,0,0));
    check("lu_stall1", 32'(stall_cnt), 32'd1);

    // Data wait of three cycles, then dhit while the fetch is still outstanding.
    do_reset();
    for (int i = 0; i < 3; i++) step("dwait", mk(1,0,1,0,0,0,0,0,0,0,0,0));
    drive(mk(0,1,1,0,0,0,0,0,0,0,0,0));
    #2;
    check("dhit_cycle", 32'(outs), 32'b0011_0010_0);
    model_advance(mk(0,1,1,0,0,0,0,0,0,0,0,0));
    @(negedge CLK);
    check("dwait_stall4", 32'(stall_cnt), 32'd4);

    // Branch taken with a coincident load-use: branch wins.
    do_reset();
    step("br_lu", mk(1,0,0,0,0,1,1,5,5,0,0,1));
    check("br_flush1", 32'(flush_cnt), 32'd1);

    // Jump waits for the fetch to complete before squashing.
    do_reset();
    step("jmp_wait0", mk(0,0,0,0,0,0,0,0,0,0,1,0));
    step("jmp_wait1", mk(0,0,0,0,0,0,0,0,0,0,1,0));
    check("jmp_noflush", 32'(flush_cnt), 32'd0);
    step("jmp_go", mk(1,0,0,0,0,0,0,0,0,0,1,0));
    check("jmp_flush1", 32'(flush_cnt), 32'd1);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < CMAX + 8; i++) step("sat", mk(0,0,0,0,0,0,0,0,0,0,0,0));
    check("stall_sat", 32'(stall_cnt), 32'(CMAX));

    // Halt and asynchronous reset out of it.
    do_reset();
    step("halt_cap", mk(1,0,0,0,1,0,0,0,0,0,0,0));
    check("halt_set", 32'(halt), 32'd1);
    step("halt_hold", mk(1,1,1,0,0,0,0,0,0,0,1,1));
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0));
    #3;
    nRST = 1'b0;
    #1;
    check("async_halt", 32'(halt), 32'd0);
    check("async_cnts", {16'(stall_cnt), 16'(flush_cnt)}, 32'd0);
    check("async_outs", 32'(outs), 32'h01E);
    m_halted = 1'b0; m_stall = 0; m_flush = 0;
    @(negedge CLK);
    nRST = 1'b1;

    // Random traffic against the model.
    begin
      int halted_cycles = 0;
      for (int i = 0; i < 600; i++) begin
        stim_t s;
        s.ihit  = ($urandom % 4) != 0;
        s.dhit  = ($urandom % 3) != 0;
        s.dren  = ($urandom % 4) == 0;
        s.dwen  = ($urandom % 8) == 0;
        s.mhalt = ($urandom % 120) == 0;
        s.m2r   = $urandom % 2;
        s.wen   = ($urandom % 4) != 0;
        s.wsel  = 5'($urandom % 8);
        s.rs    = 5'($urandom % 8);
        s.rt    = 5'($urandom % 8);
        s.jump  = ($urandom % 6) == 0;
        s.pcsrc = ($urandom % 6) == 0;
        step("rnd", s);
        if (m_halted) halted_cycles++;
        if (halted_cycles > 4) begin
          halted_cycles = 0;
          do_reset();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, expected completion before 500000");
    $fatal(1);
  end

endmodule
